aes_out_to_uart: RTL and testbench

AES_OUT_TO_UART -- requirements
Module: aes_out_to_uart

---
 rtl/aes_out_to_uart.sv | 133 +++++++++++++
 tb/tb_aes_out_to_uart.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_to_uart.sv
// Serialises a 128-bit AES result onto a UART line as 16 bytes of 8N1,
// most-significant byte first, with a sticky flag for results that arrive mid-frame.
module aes_out_to_uart #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  output logic         tx,
  output logic         busy,
  output logic         overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t         state_reg, state_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [3:0]     byte_idx_reg, byte_idx_next;
  logic [127:0]   shift_reg, shift_next;
  logic           tx_reg, tx_next;
  logic           overflow_reg, overflow_next;
  logic           bit_done;
  logic [7:0]     next_byte;

  assign bit_done = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    overflow_next = overflow_reg | (data_valid && (state_reg != ST_IDLE));

    case (state_reg)
      ST_IDLE: begin
        if (data_valid) begin
          state_next    = ST_START;
          shift_next    = data_in;
          cnt_next      = '0;
          bit_idx_next  = '0;
          byte_idx_next = '0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = '0;
            state_next   = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (byte_idx_reg == 4'd15) begin
            byte_idx_next = '0;
            state_next    = ST_IDLE;
          end else begin
            // The byte in flight always sits in the top 8 bits of the shift register.
            byte_idx_next = byte_idx_reg + 4'd1;
            shift_next    = {shift_reg[119:0], 8'h00};
            state_next    = ST_START;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // tx is registered from the upcoming state so the line changes on the same edge as the state.
  always_comb begin
    next_byte = shift_next[127:120];
    tx_next   = 1'b1;
    case (state_next)
      ST_IDLE:  tx_next = 1'b1;
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = next_byte[bit_idx_next];
      ST_STOP:  tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
    busy = (state_reg != ST_IDLE);
  end

  assign tx       = tx_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_aes_out_to_uart.sv
// Bench for aes_out_to_uart: frames are checked cycle by cycle against a waveform model
// computed from the 8N1 framing rules, and decoded back into bytes.
module tb_aes_out_to_uart;

  localparam int CPB   = 4;
  localparam int FRAME = 160 * CPB;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         data_valid;
  logic         tx;
  logic         busy;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  logic       samp [0:FRAME-1];
  logic [7:0] dec  [0:15];

  typedef struct {
    logic [127:0] data;
    int           inj_k;
    int           rst_k;
    logic [7:0]   b0;
    logic [7:0]   b15;
  } frame_vec_t;

  aes_out_to_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Expected line level k cycles after acceptance: 10 bit slots per byte, MSB byte first.
  function automatic logic model_tx(input logic [127:0] d, input int k);
    int slot, by, j;
    slot = k / CPB;
    by   = slot / 10;
    j    = slot % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[120 - 8 * by + (j - 1)];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Caller is at a negedge; returns at the negedge of the first frame cycle.
  task automatic pulse_valid(input logic [127:0] d);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = rnd128();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_frame(input logic [127:0] d, input int inj_k, input int rst_k, input string name);
    int   wave_err = 0;
    int   first_bad = -1;
    logic aborted = 1'b0;
    int   framing_err = 0;
    logic [7:0] by;
    for (int k = 0; k < FRAME; k++) begin
      samp[k] = tx;
      if (tx !== model_tx(d, k) || busy !== 1'b1) begin
        wave_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == inj_k) begin
        check({name, " ovf_before"}, overflow, 1'b0);
        data_in    = ~d;
        data_valid = 1'b1;
      end
      if (inj_k >= 0 && k == inj_k + 1) begin
        data_valid = 1'b0;
        check({name, " ovf_set"}, overflow, 1'b1);
      end
      if (k == rst_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({name, " rst_tx"}, tx, 1'b1);
        check({name, " rst_busy"}, busy, 1'b0);
        check({name, " rst_ovf"}, overflow, 1'b0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (wave_err != 0) $display("  %s first wave deviation at cycle %0d", name, first_bad);
    check({name, " wave_errors"}, 128'(wave_err), 128'd0);
    if (!aborted) begin
      for (int b = 0; b < 16; b++) begin
        if (samp[(b * 10) * CPB + CPB / 2] !== 1'b0) framing_err++;
        if (samp[(b * 10 + 9) * CPB + CPB / 2] !== 1'b1) framing_err++;
        for (int i = 0; i < 8; i++) by[i] = samp[(b * 10 + 1 + i) * CPB + CPB / 2];
        dec[b] = by;
        check($sformatf("%s byte%0d", name, b), by, d[127 - 8 * b -: 8]);
      end
      check({name, " framing_errors"}, 128'(framing_err), 128'd0);
      check({name, " idle_busy"}, busy, 1'b0);
      check({name, " idle_tx"}, tx, 1'b1);
      if (inj_k >= 0) check({name, " ovf_sticky"}, overflow, 1'b1);
    end
  endtask

  initial begin
    frame_vec_t vecs [0:1];
    logic [39:0] byte0_exp;
    logic [127:0] d;
    int gap;

    vecs[0] = '{data: 128'h3925841D02DC09FBDC118597196A0B32, inj_k: -1, rst_k: -1, b0: 8'h39, b15: 8'h32};
    vecs[1] = '{data: 128'h00112233445566778899AABBCCDDEEFF, inj_k: 100, rst_k: -1, b0: 8'h00, b15: 8'hFF};

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset ovf", overflow, 1'b0);

    for (int v = 0; v < 2; v++) begin
      do_reset();
      @(negedge clk);
      pulse_valid(vecs[v].data);
      check_frame(vecs[v].data, vecs[v].inj_k, vecs[v].rst_k, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table_b0", v), dec[0], vecs[v].b0);
      check($sformatf("vec%0d table_b15", v), dec[15], vecs[v].b15);
      $display("vec%0d data=%h sent, overflow=%0b", v, vecs[v].data, overflow);
    end

    // Byte 0x39 on the wire: start, 1,0,0,1,1,1,0,0 LSB first, stop; 4 cycles per bit.
    byte0_exp = {{4{1'b1}}, {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b1}}, {4{1'b1}},
                 {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}}};
    do_reset();
    @(negedge clk);
    pulse_valid(vecs[0].data);
    check_frame(vecs[0].data, -1, -1, "timing");
    for (int k = 0; k < 40; k++) begin
      if (samp[k] !== byte0_exp[k]) begin
        $display("  timing byte0 differs at cycle %0d", k);
      end
    end
    begin
      logic [39:0] got;
      for (int k = 0; k < 40; k++) got[k] = samp[k];
      check("timing byte0_bits", got, byte0_exp);
    end
    $display("timing byte0 checked");

    // Back-to-back: valid in the first idle cycle after the previous frame.
    d = rnd128();
    pulse_valid(d);
    check_frame(d, -1, -1, "b2b");
    $display("b2b data=%h sent", d);

    // Overflow set, then reset mid-frame clears everything; next frame is whole.
    d = rnd128();
    @(negedge clk);
    pulse_valid(d);
    check_frame(d, 50, 300, "midrst");
    d = rnd128();
    @(negedge clk);
    pulse_valid(d);
    check_frame(d, -1, -1, "after_rst");
    check("after_rst ovf", overflow, 1'b0);
    $display("midrst recovery data=%h sent", d);

    // Reset and data_valid together: reset wins.
    @(negedge clk);
    reset      = 1'b1;
    data_valid = 1'b1;
    data_in    = rnd128();
    @(negedge clk);
    reset      = 1'b0;
    data_valid = 1'b0;
    check("rst_dv busy", busy, 1'b0);
    check("rst_dv tx", tx, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_dv busy_later", busy, 1'b0);
    check("rst_dv tx_later", tx, 1'b1);
    $display("reset with data_valid checked");

    // Random frames with random idle gaps (0 means back-to-back).
    for (int r = 0; r < 4; r++) begin
      d   = rnd128();
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      pulse_valid(d);
      check_frame(d, -1, -1, $sformatf("rnd%0d", r));
      $display("rnd%0d gap=%0d data=%h sent", r, gap, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
